// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access size codes, AXI codes.
package ysyx_25040111_lsu_pkg;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} wstate_t;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // 11 is treated as a word access, same as 10.
  function automatic logic [2:0] size_of(input logic [1:0] mask);
    return (mask == MASK_H) ? 3'd1 : (mask[1] ? 3'd2 : 3'd0);
  endfunction
endpackage

// File: rtl/ysyx_25040111_lsu_if.sv
// AXI4 master-side bundle between the LSU and the memory fabric.
interface ysyx_25040111_lsu_if;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
           awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
           awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25040111_lsu_align.sv
// Byte-lane alignment: load extract/extend and store strobe/lane replication.
module ysyx_25040111_lsu_align
  import ysyx_25040111_lsu_pkg::*;
(
  input  logic [31:0] ld_raw,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_mask,
  input  logic        ld_sign,
  input  logic        ld_pass,
  output logic [31:0] ld_data,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_mask,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_strb
);
  logic [31:0] sh_b, sh_h;
  logic [7:0]  b;
  logic [15:0] h;

  // Halves select on off[1] only, so off=3 quietly reads the upper half.
  always_comb begin
    sh_b = ld_raw >> {ld_off, 3'b000};
    sh_h = ld_raw >> {ld_off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    if (ld_pass)
      ld_data = ld_raw;
    else begin
      case (ld_mask)
        MASK_B:  ld_data = {{24{ld_sign & b[7]}}, b};
        MASK_H:  ld_data = {{16{ld_sign & h[15]}}, h};
        default: ld_data = ld_raw;
      endcase
    end
  end

  always_comb begin
    case (st_mask)
      MASK_B: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MASK_H: begin
        st_strb  = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end
endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store unit: arbiter read/write channels to AXI4 master, independent read and write FSMs.
module ysyx_25040111_lsu
  import ysyx_25040111_lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_rvalid,
  input  logic [31:0] lsu_raddr,
  input  logic [7:0]  lsu_rlen,
  input  logic        lsu_burst,
  input  logic [1:0]  lsu_rmask,
  input  logic        lsu_rsign,
  output logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  input  logic        lsu_wvalid,
  input  logic [31:0] lsu_waddr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_wmask,
  output logic        lsu_wready,
  output logic        lsu_err,
  ysyx_25040111_lsu_if.master axi
);
  rstate_t     rstate;
  wstate_t     wstate;
  logic [1:0]  r_mask;
  logic        r_sign, r_burst;
  logic        rd_err, wr_err;
  logic [31:0] ld_data, st_wdata;
  logic [3:0]  st_strb;

  assign axi.arburst = AXI_BURST_INCR;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlen   = 8'd0;
  assign axi.wlast   = 1'b1;
  assign lsu_err     = rd_err | wr_err;

  ysyx_25040111_lsu_align u_align (
    .ld_raw  (axi.rdata),
    .ld_off  (axi.araddr[1:0]),
    .ld_mask (r_mask),
    .ld_sign (r_sign),
    .ld_pass (r_burst),
    .ld_data (ld_data),
    .st_data (lsu_wdata),
    .st_off  (lsu_waddr[1:0]),
    .st_mask (lsu_wmask),
    .st_wdata(st_wdata),
    .st_strb (st_strb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate      <= R_IDLE;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arsize  <= '0;
      axi.rready  <= 1'b0;
      lsu_rready  <= 1'b0;
      lsu_rdata   <= '0;
      rd_err      <= 1'b0;
      r_mask      <= '0;
      r_sign      <= 1'b0;
      r_burst     <= 1'b0;
    end else begin
      lsu_rready <= 1'b0;
      rd_err     <= 1'b0;
      case (rstate)
        R_IDLE: if (lsu_rvalid) begin
          axi.araddr  <= lsu_raddr;
          axi.arlen   <= lsu_burst ? lsu_rlen : 8'd0;
          axi.arsize  <= lsu_burst ? 3'd2 : size_of(lsu_rmask);
          axi.arvalid <= 1'b1;
          r_mask      <= lsu_rmask;
          r_sign      <= lsu_rsign;
          r_burst     <= lsu_burst;
          rstate      <= R_ADDR;
        end
        R_ADDR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          axi.rready  <= 1'b1;
          rstate      <= R_DATA;
        end
        R_DATA: if (axi.rvalid) begin
          lsu_rdata  <= ld_data;
          lsu_rready <= 1'b1;
          rd_err     <= (axi.rresp != AXI_RESP_OKAY);
          if (axi.rlast) begin
            axi.rready <= 1'b0;
            rstate     <= R_DONE;
          end
        end
        // Requester must drop valid before a new request is taken.
        R_DONE: if (!lsu_rvalid) rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate      <= W_IDLE;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awsize  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      lsu_wready  <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      lsu_wready <= 1'b0;
      wr_err     <= 1'b0;
      case (wstate)
        W_IDLE: if (lsu_wvalid) begin
          axi.awaddr  <= lsu_waddr;
          axi.awsize  <= size_of(lsu_wmask);
          axi.wdata   <= st_wdata;
          axi.wstrb   <= st_strb;
          axi.awvalid <= 1'b1;
          axi.wvalid  <= 1'b1;
          wstate      <= W_REQ;
        end
        W_REQ: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready)  axi.wvalid  <= 1'b0;
          // A channel is finished once its valid is low or it handshakes now.
          if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
            axi.bready <= 1'b1;
            wstate     <= W_RESP;
          end
        end
        W_RESP: if (axi.bvalid) begin
          axi.bready <= 1'b0;
          lsu_wready <= 1'b1;
          wr_err     <= (axi.bresp != AXI_RESP_OKAY);
          wstate     <= W_DONE;
        end
        W_DONE: if (!lsu_wvalid) wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed + randomized bench for the LSU with a behavioural load/store reference model.
module tb_ysyx_25040111_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        lsu_rvalid, lsu_burst, lsu_rsign, lsu_rready;
  logic [31:0] lsu_raddr, lsu_rdata;
  logic [7:0]  lsu_rlen;
  logic [1:0]  lsu_rmask;
  logic        lsu_wvalid, lsu_wready, lsu_err;
  logic [31:0] lsu_waddr, lsu_wdata;
  logic [1:0]  lsu_wmask;

  int n_tests = 0, n_fail = 0;
  int rpulse = 0, wpulse = 0, ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  logic [31:0] bq[$];

  ysyx_25040111_lsu_if axi();

  ysyx_25040111_lsu dut (
    .clock(clock), .reset(reset),
    .lsu_rvalid(lsu_rvalid), .lsu_raddr(lsu_raddr), .lsu_rlen(lsu_rlen), .lsu_burst(lsu_burst),
    .lsu_rmask(lsu_rmask), .lsu_rsign(lsu_rsign), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_wvalid(lsu_wvalid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_wready(lsu_wready), .lsu_err(lsu_err), .axi(axi)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (lsu_rready) rpulse <= rpulse + 1;
    if (lsu_wready) wpulse <= wpulse + 1;
    if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
    if (axi.awvalid && axi.awready) aw_hs <= aw_hs + 1;
    if (axi.wvalid && axi.wready) w_hs <= w_hs + 1;
    if (axi.bvalid && axi.bready) b_hs <= b_hs + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load result, straight from the byte/half/word extraction rules.
  function automatic logic [31:0] ld_ref(input logic [31:0] a, input logic [1:0] m,
                                         input logic s, input logic [31:0] d);
    int off;
    logic [31:0] v;
    off = int'(a % 4);
    if (m == 2'd0) begin
      v = (d / (32'd1 << (8 * off))) % 256;
      if (s && v >= 128) v = v - 256;
    end else if (m == 2'd1) begin
      v = (d / (32'd1 << (16 * (off / 2)))) % 65536;
      if (s && v >= 32768) v = v - 65536;
    end else v = d;
    return v;
  endfunction

  function automatic logic [31:0] size_ref(input logic [1:0] m);
    return (m == 2'd0) ? 0 : (m == 2'd1) ? 1 : 2;
  endfunction

  function automatic logic [31:0] strb_ref(input logic [31:0] a, input logic [1:0] m);
    int off;
    off = int'(a % 4);
    if (m == 2'd0) return 32'd1 << off;
    if (m == 2'd1) return (off < 2) ? 3 : 12;
    return 15;
  endfunction

  function automatic logic [31:0] wdata_ref(input logic [31:0] d, input logic [1:0] m);
    if (m == 2'd0) return (d % 256) * 32'h0101_0101;
    if (m == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // Starts and ends on a negedge. Beat data comes from bq, else random.
  task automatic do_read(input logic [31:0] a, input logic [1:0] m, input logic s, input logic bu,
                         input logic [7:0] len, input logic [1:0] resp, input int ar_dly, input int hold);
    int nb, p0, a0;
    logic [31:0] d;
    nb = bu ? int'(len) + 1 : 1;
    p0 = rpulse; a0 = ar_hs;
    lsu_rvalid = 1; lsu_raddr = a; lsu_rmask = m; lsu_rsign = s; lsu_burst = bu; lsu_rlen = len;
    @(negedge clock);
    chk("arvalid_lat", axi.arvalid, 1);
    chk("araddr", axi.araddr, a);
    chk("arlen", axi.arlen, bu ? len : 0);
    chk("arsize", axi.arsize, bu ? 2 : size_ref(m));
    chk("arburst", axi.arburst, 1);
    repeat (ar_dly) begin
      @(negedge clock);
      chk("arvalid_hold", axi.arvalid, 1);
    end
    axi.arready = 1;
    @(negedge clock);
    axi.arready = 0;
    chk("arvalid_drop", axi.arvalid, 0);
    for (int i = 0; i < nb; i++) begin
      d = (bq.size() > 0) ? bq.pop_front() : $urandom;
      chk("rready", axi.rready, 1);
      axi.rvalid = 1; axi.rdata = d; axi.rlast = (i == nb - 1); axi.rresp = resp;
      @(negedge clock);
      axi.rvalid = 0; axi.rlast = 0;
      chk("lsu_rready", lsu_rready, 1);
      chk("lsu_rdata", lsu_rdata, bu ? d : ld_ref(a, m, s, d));
      chk("lsu_err_r", lsu_err, resp != 0);
    end
    chk("rready_off", axi.rready, 0);
    repeat (hold + 1) begin
      @(negedge clock);
      chk("no_second_ar", axi.arvalid, 0);
      chk("no_extra_rpulse", lsu_rready, 0);
    end
    lsu_rvalid = 0;
    @(negedge clock);
    chk("rpulse_count", rpulse - p0, nb);
    chk("ar_count", ar_hs - a0, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m,
                          input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] br);
    int mx, p0, aw0, w0, b0;
    p0 = wpulse; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    lsu_wvalid = 1; lsu_waddr = a; lsu_wdata = d; lsu_wmask = m;
    @(negedge clock);
    chk("awaddr", axi.awaddr, a);
    chk("awsize", axi.awsize, size_ref(m));
    chk("awlen", axi.awlen, 0);
    chk("awburst", axi.awburst, 1);
    chk("wstrb", axi.wstrb, strb_ref(a, m));
    chk("wdata", axi.wdata, wdata_ref(d, m));
    chk("wlast", axi.wlast, 1);
    for (int c = 0; c <= mx; c++) begin
      chk("awvalid", axi.awvalid, c <= aw_dly);
      chk("wvalid", axi.wvalid, c <= w_dly);
      chk("bready_early", axi.bready, 0);
      axi.awready = (c == aw_dly);
      axi.wready  = (c == w_dly);
      @(negedge clock);
    end
    axi.awready = 0; axi.wready = 0;
    chk("awvalid_off", axi.awvalid, 0);
    chk("wvalid_off", axi.wvalid, 0);
    chk("bready", axi.bready, 1);
    repeat (b_dly) begin
      @(negedge clock);
      chk("bready_hold", axi.bready, 1);
      chk("wready_early", lsu_wready, 0);
    end
    axi.bvalid = 1; axi.bresp = br;
    @(negedge clock);
    axi.bvalid = 0;
    chk("lsu_wready", lsu_wready, 1);
    chk("lsu_err_w", lsu_err, br != 0);
    chk("bready_drop", axi.bready, 0);
    @(negedge clock);
    chk("lsu_wready_pulse", lsu_wready, 0);
    lsu_wvalid = 0;
    @(negedge clock);
    chk("aw_count", aw_hs - aw0, 1);
    chk("w_count", w_hs - w0, 1);
    chk("b_count", b_hs - b0, 1);
    chk("wpulse_count", wpulse - p0, 1);
  endtask

  initial begin
    reset = 1;
    lsu_rvalid = 0; lsu_raddr = 0; lsu_rlen = 0; lsu_burst = 0; lsu_rmask = 0; lsu_rsign = 0;
    lsu_wvalid = 0; lsu_waddr = 0; lsu_wdata = 0; lsu_wmask = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    repeat (3) @(negedge clock);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_lsu_rready", lsu_rready, 0);
    chk("rst_lsu_wready", lsu_wready, 0);
    chk("rst_lsu_err", lsu_err, 0);
    chk("rst_lsu_rdata", lsu_rdata, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", axi.wstrb, 0);
    reset = 0;
    @(negedge clock);

    bq.push_back(32'h8012_3456);
    do_read(32'h8000_0003, 2'b00, 1, 0, 0, 2'b00, 1, 0);
    bq.push_back(32'h11); bq.push_back(32'h22); bq.push_back(32'h33); bq.push_back(32'h44);
    do_read(32'h3000_0000, 2'b10, 0, 1, 8'd3, 2'b00, 0, 0);
    do_write(32'h2000_0002, 32'h1234_BEEF, 2'b01, 0, 0, 2, 2'b00);
    do_write(32'h2000_0010, 32'hCAFE_F00D, 2'b10, 3, 0, 0, 2'b00);
    fork
      do_read(32'h4000_0004, 2'b10, 0, 0, 0, 2'b00, 1, 2);
      do_write(32'h5000_0001, 32'h0000_00A5, 2'b00, 0, 2, 1, 2'b00);
    join
    do_read(32'h4000_0002, 2'b01, 1, 0, 0, 2'b10, 0, 0);
    do_write(32'h5000_0008, 32'h7777_8888, 2'b11, 1, 1, 0, 2'b10);

    // Reset while the read sits in R_DATA with a beat on the bus.
    lsu_rvalid = 1; lsu_raddr = 32'h6000_0000; lsu_rmask = 2'b10; lsu_burst = 0; lsu_rsign = 0;
    @(negedge clock);
    axi.arready = 1;
    @(negedge clock);
    axi.arready = 0;
    chk("pre_rst_rready", axi.rready, 1);
    axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF; axi.rlast = 1; reset = 1;
    @(negedge clock);
    chk("midrst_rready", axi.rready, 0);
    chk("midrst_arvalid", axi.arvalid, 0);
    chk("midrst_lsu_rready", lsu_rready, 0);
    reset = 0; axi.rvalid = 0; axi.rlast = 0; lsu_rvalid = 0;
    @(negedge clock);
    chk("midrst_idle_arvalid", axi.arvalid, 0);
    do_read(32'h6000_0001, 2'b00, 0, 0, 0, 2'b00, 0, 0);

    for (int k = 0; k < 12; k++)
      do_read($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0,
              $urandom_range(0, 1) ? 2'b10 : 2'b00, $urandom_range(0, 2), $urandom_range(0, 1));
    for (int k = 0; k < 4; k++)
      do_read($urandom, 2'b10, 0, 1, 8'($urandom_range(0, 4)), 2'b00, $urandom_range(0, 1), 0);
    for (int k = 0; k < 10; k++)
      do_write($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1) ? 2'b11 : 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
